// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory responder.
// State encoding, word and strobe widths, and the byte-merge helper.
package dmem_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } dmem_state_e;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [DataWidth-1:0] apply_strobe(
        input logic [DataWidth-1:0] old_word,
        input logic [DataWidth-1:0] new_word,
        input logic [StrbWidth-1:0] strb
    );
        logic [DataWidth-1:0] res;
        res = old_word;
        for (int b = 0; b < StrbWidth; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_storage_array.sv
// Word-organised storage with a synchronous byte-strobed write port,
// an asynchronous read port and a synchronous whole-array clear.
module dmem_storage_array
    import dmem_pkg::*;
#(
    parameter int unsigned Depth     = 128,
    parameter int unsigned AddrWidth = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                 clk_i,
    input  logic                 clear_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [StrbWidth-1:0] wstrb_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [DataWidth-1:0] rdata_o
);

    logic [DataWidth-1:0] mem_q [Depth];

    // Clear wins over a coincident write so a reset never leaves stale data.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= apply_strobe(mem_q[waddr_i], wdata_i, wstrb_i);
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_memory_responder.sv
// Single-outstanding request/response data memory with programmable wait states.
// Optional DMEM_MISALIGN_CHECK_EN rejects requests whose address is not word aligned.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int unsigned MEMORY_SIZE = 128,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int unsigned IdxWidth = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
    localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic                 write_q, write_d;
    logic [31:0]          addr_q, addr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [StrbWidth-1:0] wstrb_q, wstrb_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 error_q, error_d;

    logic                 range_err;
    logic                 misalign_err;
    logic                 req_err;
    logic                 mem_we;
    logic [DataWidth-1:0] mem_rdata;

    assign range_err = ({2'b00, addr_q[31:2]} >= MEMORY_SIZE);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign_err = |addr_q[1:0];
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr_q[1:0];
    assign misalign_err    = 1'b0;
`endif

    assign req_err = range_err | misalign_err;

    // The counter runs from WAIT_STATES down to zero, so RESP is entered
    // WAIT_STATES+1 edges after acceptance for every legal setting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        error_d = error_q;
        mem_we  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    cnt_d   = WaitInit;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    error_d = req_err;
                    rdata_d = (!write_q && !req_err) ? mem_rdata : '0;
                    mem_we  = write_q && !req_err;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                    rdata_d = '0;
                    error_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    dmem_storage_array #(
        .Depth     (MEMORY_SIZE),
        .AddrWidth (IdxWidth)
    ) u_storage (
        .clk_i   (CLK),
        .clear_i (RESET),
        .we_i    (mem_we),
        .waddr_i (addr_q[IdxWidth+1:2]),
        .wdata_i (wdata_q),
        .wstrb_i (wstrb_q),
        .raddr_i (addr_q[IdxWidth+1:2]),
        .rdata_o (mem_rdata)
    );

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;

endmodule
